// File: rtl/ram_access_ctrl_if.sv
// Request/response and RAM-strobe bundle for ram_access_ctrl.
// master = requester + RAM side, slave = controller.
interface ram_access_ctrl_if #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              wr_done;
    logic              wr_err;
    logic              err_clr;
    logic              read_write;
    logic              memory_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] in;
    logic [DATA_W-1:0] out;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready, err_clr, out,
        input  req_ready, rsp_valid, rsp_data, wr_done, wr_err,
               read_write, memory_en, address, in
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready, err_clr, out,
        output req_ready, rsp_valid, rsp_data, wr_done, wr_err,
               read_write, memory_en, address, in
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// Sequences valid/ready requests into setup/access strobes for a small RAM.
// Optional write readback check: define RAM_ACCESS_CTRL_READBACK_EN.
module ram_access_ctrl #(
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_access_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_ACCESS  = 3'd2,
        S_RESP    = 3'd3
`ifdef RAM_ACCESS_CTRL_READBACK_EN
       ,S_VSETUP  = 3'd4,
        S_VACCESS = 3'd5
`endif
    } state_e;

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              wr_done_q, wr_done_d;
    logic              read_write_q, read_write_d;
    logic              memory_en_q, memory_en_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] in_q, in_d;
    logic              mismatch_c;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            wr_done_q    <= 1'b0;
            read_write_q <= 1'b0;
            memory_en_q  <= 1'b0;
            address_q    <= '0;
            in_q         <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            wr_done_q    <= wr_done_d;
            read_write_q <= read_write_d;
            memory_en_q  <= memory_en_d;
            address_q    <= address_d;
            in_q         <= in_d;
        end
    end

    // Next state; RAM strobes are loaded at accept and held until the next accept
    always_comb begin
        state_d      = state_q;
        rsp_data_d   = rsp_data_q;
        wr_done_d    = 1'b0;
        read_write_d = read_write_q;
        address_d    = address_q;
        in_d         = in_q;
        mismatch_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    state_d      = S_SETUP;
                    read_write_d = bus.req_write;
                    address_d    = bus.req_addr;
                    in_d         = bus.req_wdata;
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (read_write_q) begin
`ifdef RAM_ACCESS_CTRL_READBACK_EN
                    state_d      = S_VSETUP;
                    read_write_d = 1'b0;
`else
                    state_d   = S_IDLE;
                    wr_done_d = 1'b1;
`endif
                end else begin
                    state_d    = S_RESP;
                    rsp_data_d = bus.out;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
`ifdef RAM_ACCESS_CTRL_READBACK_EN
            S_VSETUP: state_d = S_VACCESS;
            S_VACCESS: begin
                state_d    = S_IDLE;
                wr_done_d  = 1'b1;
                mismatch_c = (bus.out != in_q);
            end
`endif
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
`ifdef RAM_ACCESS_CTRL_READBACK_EN
        memory_en_d = (state_d == S_ACCESS) || (state_d == S_VACCESS);
`else
        memory_en_d = (state_d == S_ACCESS);
`endif
    end

`ifdef RAM_ACCESS_CTRL_READBACK_EN
    logic wr_err_q, wr_err_d;

    // Sticky error: a fresh mismatch beats a same-cycle clear
    always_comb begin
        wr_err_d = wr_err_q;
        if (mismatch_c)       wr_err_d = 1'b1;
        else if (bus.err_clr) wr_err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_err_q <= 1'b0;
        else        wr_err_q <= wr_err_d;
    end

    assign bus.wr_err = wr_err_q;
`else
    logic unused_err_clr_c;
    assign unused_err_clr_c = bus.err_clr | mismatch_c;
    assign bus.wr_err       = 1'b0;
`endif

    assign bus.req_ready  = req_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.wr_done    = wr_done_q;
    assign bus.read_write = read_write_q;
    assign bus.memory_en  = memory_en_q;
    assign bus.address    = address_q;
    assign bus.in         = in_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: RAM model, reference memory array and timing expectations
// derived from the request/setup/access/response sequence.
`timescale 1ns/1ps
module tb_ram_access_ctrl;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [DATA_W-1:0] ram     [4] = '{default: '0};
    logic [DATA_W-1:0] exp_mem [4] = '{default: '0};
    logic              corrupt_rb = 1'b0;
    logic              err_model  = 1'b0;

    logic              prev_en = 1'b0;
    logic              prev_rw = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_in = '0;

    ram_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous write, combinational read; corrupt_rb zeroes read data
    always @(posedge clk) begin
        if (bus.memory_en && bus.read_write) ram[bus.address] <= bus.in;
    end
    assign bus.out = (corrupt_rb && !bus.read_write) ? '0 : ram[bus.address];

    // Enable must be a single-cycle pulse with strobes unchanged from the cycle before
    always @(negedge clk) begin
        if (rst_n && bus.memory_en) begin
            n_checks++;
            if (prev_en !== 1'b0 || bus.address !== prev_addr || bus.in !== prev_in ||
                bus.read_write !== prev_rw) begin
                n_fail++;
                $display("FAIL en_stable: en/addr/in/rw=%b/%h/%h/%b prev=%b/%h/%h/%b",
                         bus.memory_en, bus.address, bus.in, bus.read_write,
                         prev_en, prev_addr, prev_in, prev_rw);
            end
        end
        prev_en   <= bus.memory_en;
        prev_addr <= bus.address;
        prev_in   <= bus.in;
        prev_rw   <= bus.read_write;
    end

    task automatic wait_ready(output int waits);
        waits = 0;
        while (bus.req_ready !== 1'b1 && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_timeout: got %b after %0d cycles, need 1", bus.req_ready, waits);
        end
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, output int waits);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = a; bus.req_wdata = d;
        wait_ready(waits);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = ADDR_W'($urandom);
        bus.req_wdata = DATA_W'($urandom);
        n_checks++;
        if (bus.memory_en !== 1'b0 || bus.read_write !== 1'b1 || bus.address !== a ||
            bus.in !== d || bus.req_ready !== 1'b0 || bus.wr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_setup: en=%b rw=%b addr=%h in=%h rdy=%b done=%b, need 0 1 %h %h 0 0",
                     bus.memory_en, bus.read_write, bus.address, bus.in, bus.req_ready, bus.wr_done, a, d);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.memory_en !== 1'b1 || bus.read_write !== 1'b1 || bus.wr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_access: en=%b rw=%b done=%b, need 1 1 0", bus.memory_en, bus.read_write, bus.wr_done);
        end
        @(posedge clk); #1;
`ifdef RAM_ACCESS_CTRL_READBACK_EN
        n_checks++;
        if (bus.memory_en !== 1'b0 || bus.read_write !== 1'b0 || bus.wr_done !== 1'b0 || bus.address !== a) begin
            n_fail++;
            $display("FAIL rb_setup: en=%b rw=%b done=%b addr=%h, need 0 0 0 %h",
                     bus.memory_en, bus.read_write, bus.wr_done, bus.address, a);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.memory_en !== 1'b1 || bus.read_write !== 1'b0 || bus.wr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rb_access: en=%b rw=%b done=%b, need 1 0 0", bus.memory_en, bus.read_write, bus.wr_done);
        end
        @(posedge clk); #1;
        if (corrupt_rb && d != '0) err_model = 1'b1;
`endif
        exp_mem[a] = d;
        n_checks++;
        if (bus.wr_done !== 1'b1 || bus.memory_en !== 1'b0 || bus.req_ready !== 1'b1 || bus.wr_err !== err_model) begin
            n_fail++;
            $display("FAIL wr_done: done=%b en=%b rdy=%b err=%b, need 1 0 1 %b",
                     bus.wr_done, bus.memory_en, bus.req_ready, bus.wr_err, err_model);
        end
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input int hold, output int waits);
        logic [DATA_W-1:0] exp_d;
        exp_d = exp_mem[a];
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a; bus.req_wdata = DATA_W'($urandom);
        bus.rsp_ready = (hold == 0);
        wait_ready(waits);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n_checks++;
        if (bus.memory_en !== 1'b0 || bus.read_write !== 1'b0 || bus.address !== a || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_setup: en=%b rw=%b addr=%h rdy=%b, need 0 0 %h 0",
                     bus.memory_en, bus.read_write, bus.address, bus.req_ready, a);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.memory_en !== 1'b1 || bus.read_write !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_access: en=%b rw=%b rsp_valid=%b, need 1 0 0", bus.memory_en, bus.read_write, bus.rsp_valid);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d || bus.memory_en !== 1'b0 || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_rsp: valid=%b data=%h en=%b rdy=%b, need 1 %h 0 0",
                     bus.rsp_valid, bus.rsp_data, bus.memory_en, bus.req_ready, exp_d);
        end
        if (hold > 0) begin
            // A competing write is offered during backpressure and must be ignored
            bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = ~a; bus.req_wdata = ~exp_d;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                n_checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d || bus.req_ready !== 1'b0 || bus.memory_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rd_hold: valid=%b data=%h rdy=%b en=%b, need 1 %h 0 0",
                             bus.rsp_valid, bus.rsp_data, bus.req_ready, bus.memory_en, exp_d);
                end
            end
            bus.req_valid = 1'b0;
            bus.rsp_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_done: valid=%b rdy=%b, need 0 1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b0; bus.err_clr = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.memory_en, bus.read_write, bus.address, bus.in, bus.rsp_valid, bus.rsp_data,
             bus.wr_done, bus.wr_err, bus.req_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: en=%b rw=%b addr=%h in=%h rv=%b rd=%h done=%b err=%b rdy=%b, need all 0",
                     bus.memory_en, bus.read_write, bus.address, bus.in, bus.rsp_valid, bus.rsp_data,
                     bus.wr_done, bus.wr_err, bus.req_ready);
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, need 0 before first edge", bus.req_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_edge_ready: got %b, need 1", bus.req_ready);
        end
    endtask

    task automatic test_write_read();
        int w;
        do_write(2'd2, 4'hA, w);
        do_read(2'd2, 0, w);
    endtask

    task automatic test_backpressure();
        int w;
        do_read(2'd2, 5, w);
        do_read(2'd2, 0, w);
    endtask

    task automatic test_back_to_back();
        int w;
        for (int i = 0; i < 4; i++) begin
            do_write(ADDR_W'(i), DATA_W'(5 + i), w);
            if (i > 0) begin
                n_checks++;
                if (w !== 0) begin
                    n_fail++;
                    $display("FAIL b2b_write_gap: waited %0d cycles, need 0", w);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            do_read(ADDR_W'(i), 0, w);
            if (i > 0) begin
                n_checks++;
                if (w !== 0) begin
                    n_fail++;
                    $display("FAIL b2b_read_gap: waited %0d cycles, need 0", w);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int w;
        logic [DATA_W-1:0] old_d;
        old_d = exp_mem[3];
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 2'd3; bus.req_wdata = ~old_d;
        wait_ready(w);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.memory_en !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_access_en: got %b, need 1", bus.memory_en);
        end
        #2 rst_n = 1'b0;
        err_model = 1'b0;
        #1;
        n_checks++;
        if ({bus.memory_en, bus.read_write, bus.address, bus.in, bus.rsp_valid, bus.rsp_data,
             bus.wr_done, bus.wr_err, bus.req_ready} !== '0) begin
            n_fail++;
            $display("FAIL mid_access_reset: en=%b rw=%b addr=%h in=%h rv=%b rd=%h done=%b err=%b rdy=%b, need all 0",
                     bus.memory_en, bus.read_write, bus.address, bus.in, bus.rsp_valid, bus.rsp_data,
                     bus.wr_done, bus.wr_err, bus.req_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_read(2'd3, 0, w);
    endtask

    task automatic test_readback_err();
        int w;
        corrupt_rb = 1'b1;
        do_write(2'd1, 4'hF, w);
        corrupt_rb = 1'b0;
        exp_mem[1] = 4'hF;
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++;
            if (bus.wr_err !== err_model || bus.address !== 2'd1 || bus.in !== 4'hF || bus.memory_en !== 1'b0) begin
                n_fail++;
                $display("FAIL err_sticky_idle: err=%b addr=%h in=%h en=%b, need %b 1 f 0",
                         bus.wr_err, bus.address, bus.in, bus.memory_en, err_model);
            end
        end
        bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
        err_model = 1'b0;
        n_checks++;
        if (bus.wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clr: got %b, need 0", bus.wr_err);
        end
        do_read(2'd1, 0, w);
    endtask

    task automatic test_random();
        int w;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(1, 0) == 1)
                do_write(ADDR_W'($urandom), DATA_W'($urandom), w);
            else
                do_read(ADDR_W'($urandom), int'($urandom_range(3, 0)), w);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_access();
        test_readback_err();
        test_random();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
